// File: rtl/dsp_xintf_bridge.sv
// DSP XINTF to dual DPBRAM bridge.
// Reads are served combinationally from the raw bus pins. Writes pass through a
// synchroniser and a settle FSM that commits exactly one BRAM write per WE strobe.
// Optional build macro: XINTF_ADDR_CHK_EN (range check on committed write addresses).
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE   (0) | bus quiet or owned by the waveform engine
// WR_WAIT(1) | CS&WE seen, counting settle cycles before sampling XA/XD
// WR_COMMIT(2)| single-cycle write-bank strobe with the latched values
// WR_HOLD(3) | strobe still asserted, waiting for release before re-arming
`timescale 1ns/1ps
module dsp_xintf_bridge #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int SYNC_STG  = 2,
    parameter int WR_SETTLE = 3,
    parameter int ADDR_MAX  = 511
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wf_en,
    input  logic              i_nZ_CS,
    input  logic              i_nZ_WE,
    input  logic              i_nZ_RD,
    input  logic [ADDR_W-1:0] i_Z_XA,
    inout  wire  [DATA_W-1:0] io_Z_XD,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_ce,
    input  logic [DATA_W-1:0] i_rd_dout,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_ce,
    output logic              o_wr_we,
    output logic [DATA_W-1:0] o_wr_din,
    output logic [15:0]       o_wr_cnt,
    output logic              o_short_err,
    output logic              o_addr_err,
    input  logic              i_err_clr,
    output logic [2:0]        o_state
);

    localparam int CNT_W = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_WAIT   = 2'd1,
        ST_WR_COMMIT = 2'd2,
        ST_WR_HOLD   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STG-1:0] we_sync_q, we_sync_d;
    logic [SYNC_STG-1:0] rd_sync_q, rd_sync_d;
    logic                wr_act;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_data_q, lat_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_din_q, wr_din_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic              addr_err_q, addr_err_d;
    logic              addr_ok;
    logic              commit;
    logic              short_err;
    logic              rd_oe;

    // strobe pins shift in active-high; the last stage is the synchronised strobe
    always_comb begin
        cs_sync_d = {cs_sync_q[SYNC_STG-2:0], ~i_nZ_CS};
        we_sync_d = {we_sync_q[SYNC_STG-2:0], ~i_nZ_WE};
        rd_sync_d = {rd_sync_q[SYNC_STG-2:0], ~i_nZ_RD};
    end

    assign wr_act = cs_sync_q[SYNC_STG-1] & we_sync_q[SYNC_STG-1];

    // the read strobe is synchronised for completeness but the read path runs off the raw pins
    logic unused_rd_s;
    assign unused_rd_s = rd_sync_q[SYNC_STG-1];

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic; the waveform engine pre-empts every state
    always_comb begin
        state_d = state_q;
        if (i_wf_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (wr_act) state_d = ST_WR_WAIT;
                ST_WR_WAIT:   if (!wr_act) state_d = ST_IDLE;
                              else if (cnt_q == CNT_LAST) state_d = ST_WR_COMMIT;
                ST_WR_COMMIT: state_d = ST_WR_HOLD;
                ST_WR_HOLD:   if (!wr_act) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        short_err  = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: cnt_d = '0;
            ST_WR_WAIT: begin
                if (!i_wf_en) begin
                    if (!wr_act) begin
                        short_err = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        lat_addr_d = i_Z_XA;
                        lat_data_d = io_Z_XD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WR_COMMIT: commit = !i_wf_en && addr_ok;
            default: ;
        endcase
        commit    = commit & ~i_rst;
        short_err = short_err & ~i_rst;
        wr_cnt_d  = wr_cnt_q + 16'(commit);
        wr_addr_d = commit ? lat_addr_q : wr_addr_q;
        wr_din_d  = commit ? lat_data_q : wr_din_q;

        o_wr_ce     = commit;
        o_wr_we     = commit;
        o_wr_addr   = wr_addr_d;
        o_wr_din    = wr_din_d;
        o_wr_cnt    = wr_cnt_q;
        o_short_err = short_err;
        o_addr_err  = addr_err_q;
        o_state     = {1'b0, state_q};
    end

`ifdef XINTF_ADDR_CHK_EN
    assign addr_ok = (int'(lat_addr_q) <= ADDR_MAX);

    // sticky range error; a fresh error outranks a same-cycle clear
    always_comb begin
        addr_err_d = addr_err_q;
        if (state_q == ST_WR_COMMIT && !i_wf_en && !addr_ok) addr_err_d = 1'b1;
        else if (i_err_clr)                                  addr_err_d = 1'b0;
    end
`else
    localparam int unused_addr_max = ADDR_MAX;
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign addr_ok        = 1'b1;

    // without the range check the error flag never sets
    always_comb begin
        addr_err_d = 1'b0;
    end
`endif

    // synchroniser chains, settle counter, latches and committed-write history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_sync_q  <= '0;
            we_sync_q  <= '0;
            rd_sync_q  <= '0;
            cnt_q      <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
            wr_cnt_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            we_sync_q  <= we_sync_d;
            rd_sync_q  <= rd_sync_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_din_q   <= wr_din_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    // read path: raw pins, write strobe wins, waveform engine and reset keep the bus off
    assign rd_oe     = ~i_nZ_CS & ~i_nZ_RD & i_nZ_WE & ~i_wf_en & ~i_rst;
    assign o_rd_ce   = rd_oe;
    assign o_rd_addr = rd_oe ? i_Z_XA : '0;
    assign io_Z_XD   = rd_oe ? i_rd_dout : 'z;

endmodule
